// File: rtl/clkgen_multi.sv
// clkgen_multi: NCH independent divided clocks, each with programmable period, high time
// and start phase. Config is double-buffered and taken up only at period boundaries.
module clkgen_multi #(
  parameter  int unsigned NCH = 2,
  parameter  int unsigned CW  = 16,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic [CW-1:0]  cfg_phase,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] running
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PHASE = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic [CW-1:0] phase;
  } cfg_t;

  // Phase is consumed when the channel launches, so the running set keeps only P and H.
  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
  } run_cfg_t;

  localparam cfg_t     CFG_RST = {CW'(2), CW'(1), CW'(0)};
  localparam run_cfg_t RUN_RST = {CW'(2), CW'(1)};

  cfg_t cfg_wr;
  assign cfg_wr = {cfg_period, cfg_high, cfg_phase};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] p_eff;
    cfg_t          staged_q, staged_d;
    run_cfg_t      active_q, active_d;
    logic          wr_hit;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          run_q, run_d;

    assign wr_hit = cfg_we && (cfg_ch == CHW'(i));
    assign p_eff  = (active_q.period < CW'(2)) ? CW'(2) : active_q.period;

    // State, counters, config buffers and output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        pcnt_q   <= '0;
        staged_q <= CFG_RST;
        active_q <= RUN_RST;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        run_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        pcnt_q   <= pcnt_d;
        staged_q <= staged_d;
        active_q <= active_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        run_q    <= run_d;
      end
    end

    // Next state, counter and config transfer; outputs come from the present state.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pcnt_d   = pcnt_q;
      active_d = active_q;
      staged_d = wr_hit ? cfg_wr : staged_q;
      clk_d    = (state_q == S_RUN) && (cnt_q < active_q.high);
      tick_d   = (state_q == S_RUN) && (cnt_q == '0) && (active_q.high != '0);
      run_d    = (state_q == S_RUN);

      case (state_q)
        S_IDLE: begin
          cnt_d    = '0;
          pcnt_d   = '0;
          active_d = {staged_q.period, staged_q.high};
          if (en[i]) begin
            if (staged_q.phase == '0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_PHASE;
              pcnt_d  = staged_q.phase - CW'(1);
            end
          end
        end
        S_PHASE: begin
          if (pcnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            pcnt_d = pcnt_q - CW'(1);
          end
        end
        S_RUN: begin
          // Wrap edge: the only point where a running channel picks up new config.
          if (cnt_q >= p_eff - CW'(1)) begin
            cnt_d    = '0;
            active_d = {staged_q.period, staged_q.high};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pcnt_d  = '0;
        end
      endcase

      if (!en[i]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pcnt_d  = '0;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign running[i] = run_q;
  end

endmodule

// File: doc/clkgen_multi.md
# clkgen_multi

Synthesisable multi-channel clock/strobe generator for RTL. It derives NCH independent divided clocks from the system clock `clk`. Each channel has a programmable period, high time and start phase, held in double-buffered config registers. Updates apply only at period boundaries, so outputs never glitch or shorten a cycle. It is the hardware counterpart of the bench-side frequency/duty/phase clock tasks, and it feeds enables and derived clocks to peripheral blocks.

## Interface
- NCH, 2: number of output channels (1..16)
- CW, 16: width of period/high/phase counters and config fields
- CHW, (NCH>1 ? $clog2(NCH) : 1): channel-select width (derived, not overridden)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  NCH  per-channel run enable, level-sensitive
- cfg_we  in  1  config write strobe
- cfg_ch  in  CHW  channel addressed by the write
- cfg_period  in  CW  period P in clk cycles
- cfg_high  in  CW  high time H in clk cycles
- cfg_phase  in  CW  start delay D in clk cycles
- clk_out  out  NCH  generated clocks, registered
- tick  out  NCH  1-cycle strobe aligned with each clk_out period start
- running  out  NCH  channel in RUN state

## Operation
- Each channel has a staged config set (written by cfg_we) and an active config set (used by the counters).
- A write with cfg_ch >= NCH is ignored.
- Effective period: P_eff = max(P, 2).
- H = 0: clk_out stays low and tick never fires.
- H >= P_eff: clk_out stays high and tick fires at each cnt==0.
- Per-channel FSM with states IDLE, PHASE and RUN:
  - IDLE: cnt=0; active <= staged every cycle. If en=1: go to RUN with cnt=0 when D==0, otherwise go to PHASE with pcnt=D-1.
  - PHASE: active held. If pcnt==0, go to RUN with cnt=0; otherwise pcnt--.
  - RUN: cnt <= (cnt==P_eff-1) ? 0 : cnt+1. On the wrap edge, active <= staged.
  - en=0 in any state: next state IDLE, cnt=0, pcnt=0.
- Output registers:
  - clk_out <= (state==RUN && cnt < H_act)
  - tick <= (state==RUN && cnt==0 && H_act!=0)
  - running <= (state==RUN)
- Counters compare unsigned at width CW and never exceed P_eff-1.

## Timing
- Reset values: state IDLE, cnt=0, pcnt=0, clk_out=0, tick=0, running=0. Staged and active both reset to P=2, H=1, D=0 (divide-by-2, 50%).
- rst overrides en and cfg_we on the same edge. Reset mid-operation returns to reset values at that edge, including the staged config.
- Start latency: en sampled high at edge k in IDLE.
  - First clk_out rise and first tick appear after edge k+D+1.
  - running rises after edge k+D+1.
- Steady state: clk_out high for exactly min(H,P_eff) cycles, then low for P_eff-H cycles, repeating every P_eff cycles. tick is coincident with each clk_out rising cycle.
- Stop latency: en sampled low at edge k.
  - state is IDLE after edge k.
  - clk_out, tick and running are 0 after edge k+1, truncating the current period.
- Config write at edge k:
  - IDLE channel: active takes the value after edge k+1.
  - RUN/PHASE channel: active takes the value at the first wrap edge after edge k.
- Simultaneous write and wrap on the same edge: active takes the previously staged value. The new write applies at the following wrap.
- Channels with en asserted on the same edge and identical D produce phase-aligned edges. Channels with differing D are offset by exactly D_a-D_b cycles.
- en toggled 1->0->1 across consecutive edges restarts the phase delay from D.

## Test plan
- Reset defaults: assert rst 3 cycles, set en=all-ones. After the first edge with rst low, clk_out[0] toggles every cycle and tick[0] is high on each clk_out rise.
- Divide/duty: ch0 P=10 H=3 D=0, en[0] at edge 0 -> clk_out[0] high in cycles 1-3, low in cycles 4-10, repeating every 10; tick[0] high at cycles 1, 11, 21.
- Phase offset: ch0 and ch1 both P=8 H=4, D=0 and D=3, enabled on the same edge -> ch1 rising edges lag ch0 by exactly 3 cycles for 10 periods.
- Glitch-free reconfig: ch0 running P=10 H=5. Write P=4 H=1 mid-period, including a write on a wrap edge -> the current (and, for the wrap case, the next) period completes at 10/5, then 4/1 applies; no runt pulse.
- Clamps: P=0 H=1 -> divide-by-2. H=0 -> clk_out stuck 0 with no tick. H=12 with P=8 -> clk_out stuck 1 with tick every 8 cycles. cfg_ch=NCH -> no channel changes.
- Stop/reset mid-run: drop en[0] while clk_out[0]=1 -> 0 after one more edge. Assert rst during PHASE -> all outputs 0 and config back to P=2 H=1 D=0.
